// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: rebuilds a 16-bit command from two UART frames (start, 8 data MSB first, odd parity, stop).
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around mid-bit.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned GAP_BITS     = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] cmd_out,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic        par_err,
  output logic        frm_err,
  output logic        to_err,
  output logic        ovf,
  output logic        busy
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT + 2);
  localparam int unsigned GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_LOAD = CLKS_PER_BIT / 2 + 1;
`else
  localparam int unsigned START_LOAD = CLKS_PER_BIT / 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       hi_q, hi_d;
  logic             byte_idx_q, byte_idx_d;
  logic             par_bad_q, par_bad_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             fall_c, tick_c, smp_c;
  logic             par_c, frm_c, to_c, commit_c;

  // Two-flop synchronizer plus one history stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev2 <= 1'b1;
    else        rx_prev2 <= rx_prev;
  end

  // Decision at mid+1 from samples at mid-1, mid, mid+1
  assign smp_c = (rx_s2 & rx_prev) | (rx_s2 & rx_prev2) | (rx_prev & rx_prev2);
`else
  assign smp_c = rx_s2;
`endif

  assign fall_c = rx_prev & ~rx_s2;
  assign tick_c = (cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      hi_q       <= '0;
      byte_idx_q <= 1'b0;
      par_bad_q  <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      hi_q       <= hi_d;
      byte_idx_q <= byte_idx_d;
      par_bad_q  <= par_bad_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state and event decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    hi_d       = hi_q;
    byte_idx_d = byte_idx_q;
    par_bad_d  = par_bad_q;
    gap_d      = gap_q;
    par_c      = 1'b0;
    frm_c      = 1'b0;
    to_c       = 1'b0;
    commit_c   = 1'b0;

    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP) begin
      cnt_d = tick_c ? CNT_W'(CLKS_PER_BIT - 1) : cnt_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          state_d = S_START;
          cnt_d   = CNT_W'(START_LOAD);
        end
      end
      S_START: begin
        if (tick_c) begin
          if (smp_c) begin
            // False start: resume where we were, gap timer untouched
            state_d = byte_idx_q ? S_GAP : S_IDLE;
          end else begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shreg_d = {shreg_q[6:0], smp_c};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          par_bad_d = (smp_c != ~^shreg_q);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (!smp_c) begin
            frm_c      = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = S_BREAK;
          end else if (par_bad_q) begin
            par_c      = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = S_IDLE;
          end else if (!byte_idx_q) begin
            hi_d       = shreg_q;
            byte_idx_d = 1'b1;
            gap_d      = GAP_W'(1);
            state_d    = S_GAP;
          end else begin
            commit_c   = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (fall_c) begin
          state_d = S_START;
          cnt_d   = CNT_W'(START_LOAD);
        end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          to_c       = 1'b1;
          byte_idx_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register, handshake and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out <= '0;
      cmd_vld <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      to_err  <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      par_err <= par_c;
      frm_err <= frm_c;
      to_err  <= to_c;
      ovf     <= 1'b0;
      busy    <= (state_d != S_IDLE);
      if (commit_c) begin
        if (!cmd_vld || cmd_rdy) begin
          cmd_out <= {hi_q, shreg_q};
          cmd_vld <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (cmd_vld && cmd_rdy) begin
        cmd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed frames push expected events; a negedge monitor pops and compares.
module tb_uart_cmd_rx;

  localparam int CPB      = 16;
  localparam int GAP_BITS = 22;
  localparam int GAP_CYC  = CPB * GAP_BITS;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Cycle offset from driving the start bit to the stop-bit decision cycle
  localparam int STOP_OFS = 10 * CPB + CPB / 2 + 3 + MAJ;

  typedef enum int {EV_NONE, EV_CMD, EV_PAR, EV_FRM, EV_TO, EV_OVF} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] val;
    int          cyc;
  } ev_t;

  logic        clk, rst_n, rx, cmd_rdy;
  logic [15:0] cmd_out;
  logic        cmd_vld, par_err, frm_err, to_err, ovf, busy;

  ev_t exp_q[$];
  int  cyc;
  int  n_checks;
  int  n_pass;
  logic        prev_vld, prev_rdy;
  logic [15:0] prev_out;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .par_err(par_err), .frm_err(frm_err), .to_err(to_err),
    .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_ev(input ev_kind_e k, input logic [15:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: value 0x%0h at cycle %0d, required no event", k.name(), v, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || (k == EV_CMD && e.val != v))
      $display("FAIL event_%s: got %s 0x%0h at cycle %0d, required %s 0x%0h at cycle %0d",
               e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
    else n_pass++;
  endtask

  // Monitor: every presented word or error pulse consumes one scoreboard entry
  initial begin
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_out = '0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_vld && (!prev_vld || prev_rdy)) check_ev(EV_CMD, cmd_out);
      if (cmd_vld && prev_vld && !prev_rdy) chk("cmd_out_stable", 32'(cmd_out), 32'(prev_out));
      if (par_err) check_ev(EV_PAR, 16'h0);
      if (frm_err) check_ev(EV_FRM, 16'h0);
      if (to_err)  check_ev(EV_TO, 16'h0);
      if (ovf)     check_ev(EV_OVF, 16'h0);
    end
    prev_vld = cmd_vld;
    prev_rdy = cmd_rdy;
    prev_out = cmd_out;
  end

  // Drives one 11-bit frame; optionally pulses cmd_rdy in the stop-decision cycle
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input ev_kind_e k, input logic [15:0] v, input logic rdy_pulse);
    logic [10:0] f;
    int c0;
    int bi;
    f = {1'b0, d, par, stp};
    @(posedge clk); #1;
    c0 = cyc;
    if (k == EV_TO) exp_q.push_back('{kind: k, val: v, cyc: c0 + STOP_OFS + GAP_CYC});
    else if (k != EV_NONE) exp_q.push_back('{kind: k, val: v, cyc: c0 + STOP_OFS + 1});
    for (int t = 0; t < 11 * CPB; t++) begin
      bi = 10 - t / CPB;
      rx = f[bi];
      if (rdy_pulse) cmd_rdy = (t == STOP_OFS);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    cmd_rdy  = 1'b1;
    wait_cycles(3);
    chk("reset_cmd_out", 32'(cmd_out), 32'h0);
    chk("reset_cmd_vld", 32'(cmd_vld), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err_pulses", 32'({par_err, frm_err, to_err, ovf}), 32'h0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Basic pair with the consumer always ready
    send_frame(8'hA5, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, EV_CMD, 16'hA55A, 1'b0);
    chk("a55a_consumed", 32'(cmd_vld), 32'h0);
    wait_cycles(5);

    // Parity error on frame 1; the next frame starts a fresh word and then times out
    send_frame(8'h12, 1'b0, 1'b1, EV_PAR, 16'h0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, EV_TO, 16'h0, 1'b0);
    wait_cycles(GAP_CYC);
    send_frame(8'h12, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, EV_CMD, 16'h1234, 1'b0);
    wait_cycles(5);

    // Short glitch on an idle line is a false start
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(2);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    wait_cycles(14);
    chk("glitch_busy_low", 32'(busy), 32'h0);

    // Stop bit low then a held break; busy holds until the line returns high
    send_frame(8'hFF, 1'b1, 1'b0, EV_FRM, 16'h0, 1'b0);
    wait_cycles(3 * CPB);
    chk("break_busy_high", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_cycles(6);
    chk("break_busy_low", 32'(busy), 32'h0);
    send_frame(8'hC3, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, EV_CMD, 16'hC33C, 1'b0);
    wait_cycles(5);

    // Lone frame 1 then idle: gap timeout
    send_frame(8'h77, 1'b1, 1'b1, EV_TO, 16'h0, 1'b0);
    wait_cycles(GAP_CYC);
    chk("timeout_busy_low", 32'(busy), 32'h0);

    // Overflow with a stalled consumer, then a handshake coinciding with the commit
    cmd_rdy = 1'b0;
    send_frame(8'h00, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, EV_CMD, 16'h0001, 1'b0);
    send_frame(8'h00, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b1, EV_OVF, 16'h0, 1'b0);
    chk("ovf_keeps_word", 32'(cmd_out), 32'h0001);
    chk("ovf_keeps_vld", 32'(cmd_vld), 32'h1);
    send_frame(8'h00, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b1, EV_CMD, 16'h0002, 1'b1);
    chk("swap_word", 32'(cmd_out), 32'h0002);
    chk("swap_vld", 32'(cmd_vld), 32'h1);
    cmd_rdy = 1'b1;
    wait_cycles(2);
    chk("drain_vld", 32'(cmd_vld), 32'h0);

    // Reset while holding a high byte; the partial word must not leak into the next pair
    send_frame(8'hAB, 1'b0, 1'b1, EV_NONE, 16'h0, 1'b0);
    wait_cycles(10);
    chk("gap_busy_high", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    send_frame(8'h12, 1'b1, 1'b1, EV_NONE, 16'h0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, EV_CMD, 16'h1234, 1'b0);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    wait_cycles(10);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
